// File: rtl/led_game_pkg.sv
// Shared types and constants for the LED reaction game sequencer.
package led_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_SHOW,
        ST_WAIT,
        ST_CLEAR,
        ST_FAIL,
        ST_OVER
    } state_t;

    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam int          SCORE_W          = 8;
    localparam int          HITS_PER_SPEEDUP = 4;
    localparam int          MIN_WINDOW       = 2;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/led_game_ctrl_if.sv
// Board-side bundle of the game sequencer: start/buttons/LED readback in, toggles and status out.
interface led_game_ctrl_if #(
    parameter int N_LEDS = 4
);
    logic              start;
    logic [N_LEDS-1:0] btn;
    logic [N_LEDS-1:0] led_state;
    logic [N_LEDS-1:0] toggle;
    logic [7:0]        score;
    logic              busy;
    logic              game_over;

    modport master (
        output start, btn, led_state,
        input  toggle, score, busy, game_over
    );

    modport slave (
        input  start, btn, led_state,
        output toggle, score, busy, game_over
    );
endinterface

// File: rtl/led_game_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick the next target LED.
module lfsr16
    import led_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= SEED;
        else     q <= lfsr_step(q);
    end

endmodule

// File: rtl/led_game_ctrl.sv
// Reaction game FSM: lights a random LED, waits for its button, scores or ends the game.
// The toggle register is loaded one state ahead so each pulse is visible during SHOW/CLEAR/FAIL.
module led_game_ctrl
    import led_game_pkg::*;
#(
    parameter int          N_LEDS        = 4,
    parameter int          TICK_DIV      = 50_000_000,
    parameter int          TIMEOUT_TICKS = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic           clk,
    input logic           rst,
    led_game_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(N_LEDS);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int HIT_W = $clog2(HITS_PER_SPEEDUP);

    state_t             state, state_n;
    logic [IDX_W-1:0]   target, target_n;
    logic [DIV_W-1:0]   cyc, cyc_n;
    logic [7:0]         tick, tick_n;
    logic [7:0]         window, window_n;
    logic [SCORE_W-1:0] score, score_n;
    logic [HIT_W-1:0]   hit_cnt, hit_n;
    logic [N_LEDS-1:0]  toggle, toggle_n;

    logic [15:0]        lfsr_q;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_LEDS-1:0]  tgt_mask, pick_mask;
    logic               tick_wrap, btn_other, lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign pick_idx    = lfsr_q[IDX_W-1:0];
    assign lfsr_unused = ^lfsr_q[15:IDX_W];

    always_comb begin
        tgt_mask            = '0;
        tgt_mask[target]    = 1'b1;
        pick_mask           = '0;
        pick_mask[pick_idx] = 1'b1;
    end

    assign tick_wrap = (cyc == DIV_W'(TICK_DIV - 1));
    assign btn_other = |(bus.btn & ~tgt_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            target  <= '0;
            cyc     <= '0;
            tick    <= '0;
            window  <= 8'(TIMEOUT_TICKS);
            score   <= '0;
            hit_cnt <= '0;
            toggle  <= '0;
        end else begin
            state   <= state_n;
            target  <= target_n;
            cyc     <= cyc_n;
            tick    <= tick_n;
            window  <= window_n;
            score   <= score_n;
            hit_cnt <= hit_n;
            toggle  <= toggle_n;
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        cyc_n    = cyc;
        tick_n   = tick;
        window_n = window;
        score_n  = score;
        hit_n    = hit_cnt;
        toggle_n = '0;
        unique case (state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    score_n  = '0;
                    hit_n    = '0;
                    window_n = 8'(TIMEOUT_TICKS);
                    state_n  = ST_PICK;
                end
            end
            ST_PICK: begin
                target_n = pick_idx;
                toggle_n = pick_mask & ~bus.led_state;
                state_n  = ST_SHOW;
            end
            ST_SHOW: begin
                cyc_n   = '0;
                tick_n  = '0;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                cyc_n  = tick_wrap ? '0 : cyc + 1'b1;
                tick_n = tick_wrap ? tick + 8'd1 : tick;
                // A stray button loses even if the target button is pressed too.
                if (btn_other) begin
                    toggle_n = tgt_mask & bus.led_state;
                    state_n  = ST_FAIL;
                end else if (|(bus.btn & tgt_mask)) begin
                    score_n  = (score == {SCORE_W{1'b1}}) ? score : score + 1'b1;
                    hit_n    = hit_cnt + 1'b1;
                    toggle_n = tgt_mask & bus.led_state;
                    state_n  = ST_CLEAR;
                end else if (tick_wrap && (tick + 8'd1) == window) begin
                    toggle_n = tgt_mask & bus.led_state;
                    state_n  = ST_FAIL;
                end
            end
            ST_CLEAR: begin
                // hit_cnt wrapped to zero means a full group of hits just completed.
                if (hit_cnt == '0 && window > 8'(MIN_WINDOW))
                    window_n = window - 8'd1;
                state_n = ST_PICK;
            end
            ST_FAIL: state_n = ST_OVER;
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.toggle    = toggle;
    assign bus.score     = score;
    assign bus.busy      = (state != ST_IDLE) && (state != ST_OVER);
    assign bus.game_over = (state == ST_OVER);

endmodule

// File: tb/tb_led_game_ctrl.sv
// Randomised game sessions against a rule-level model of the game and four toggle_led cells.
module tb_led_game_ctrl;

    localparam int          N    = 4;
    localparam int          DIV  = 4;
    localparam int          TO   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_game_ctrl_if #(.N_LEDS(N)) bus();

    led_game_ctrl #(
        .N_LEDS        (N),
        .TICK_DIV      (DIV),
        .TIMEOUT_TICKS (TO),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [N-1:0] leds;
    logic [15:0]  lf, lf_prev;

    function automatic logic [15:0] lf_next(input logic [15:0] q);
        logic [15:0] s;
        s = q >> 1;
        if (q[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Four toggle_led cells plus a free-running copy of the random source.
    always @(posedge clk) begin
        if (rst) begin
            leds    <= '0;
            lf      <= SEED;
            lf_prev <= SEED;
        end else begin
            leds    <= leds ^ bus.toggle;
            lf_prev <= lf;
            lf      <= lf_next(lf);
        end
    end
    assign bus.led_state = leds;

    int errs = 0;
    int nchk = 0;
    int hits = 0;
    int tgt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_win_cyc();
        int w;
        w = TO - hits / 4;
        if (w < 2) w = 2;
        return w * DIV;
    endfunction

    function automatic int exp_score();
        return (hits > 255) ? 255 : hits;
    endfunction

    task automatic show_check(input string tag);
        int idx;
        idx = 0;
        for (int i = 0; i < N; i++) if (bus.toggle[i]) idx = i;
        chk({tag, "_onehot"}, $countones(bus.toggle), 1);
        chk({tag, "_idx"}, idx, 32'(lf_prev[1:0]));
        chk({tag, "_unlit"}, leds, 0);
        tgt = 32'(lf_prev[1:0]);
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        hits = 0;
        chk("pick_busy", bus.busy, 1);
        chk("pick_over", bus.game_over, 0);
        chk("pick_score", bus.score, 0);
        step();
        show_check("show");
        step();
        chk("lit", leds, 32'(1) << tgt);
    endtask

    task automatic hit(input int k);
        for (int j = 0; j < k; j++) begin
            step();
            chk("wait_quiet", bus.toggle, 0);
        end
        bus.btn = 4'(1 << tgt);
        step();
        bus.btn = '0;
        hits++;
        chk("clr_pulse", bus.toggle, 32'(1) << tgt);
        chk("score", bus.score, exp_score());
        step();
        step();
        show_check("next");
        step();
        chk("next_lit", leds, 32'(1) << tgt);
    endtask

    task automatic over_check();
        int s;
        step();
        s = exp_score();
        chk("over_flag", bus.game_over, 1);
        chk("over_busy", bus.busy, 0);
        chk("over_score", bus.score, s);
        chk("over_leds", leds, 0);
        bus.btn = 4'($urandom_range(15, 1));
        step();
        bus.btn = '0;
        chk("over_btn_ign", {bus.game_over, bus.toggle, bus.score}, {1'b1, 4'b0, 8'(s)});
    endtask

    task automatic end_timeout();
        int n, wc;
        wc = exp_win_cyc();
        n  = 0;
        while (bus.toggle == '0 && n < 200) begin
            step();
            n++;
        end
        chk("to_cycles", (n >= wc - 1 && n <= wc + 1) ? wc : n, wc);
        chk("to_pulse", bus.toggle, 32'(1) << tgt);
        chk("to_score", bus.score, exp_score());
        over_check();
    endtask

    task automatic end_wrong(input bit with_tgt);
        int w, k;
        k = $urandom_range(exp_win_cyc() - 2, 0);
        for (int j = 0; j < k; j++) step();
        w = (tgt + 1 + int'($urandom_range(2, 0))) % N;
        bus.btn = 4'(1 << w);
        if (with_tgt) bus.btn[tgt] = 1'b1;
        step();
        bus.btn = '0;
        chk("wrong_pulse", bus.toggle, 32'(1) << tgt);
        chk("wrong_score", bus.score, exp_score());
        over_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errs + 1, nchk + 1);
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.btn   = '0;
        rst       = 1'b1;
        repeat (3) step();
        chk("rst_outs", {bus.toggle, bus.score, bus.busy, bus.game_over}, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_outs", {bus.toggle, bus.score, bus.busy, bus.game_over}, 0);
        end

        // Random hits including one in the exact timeout cycle, then a stray button.
        start_game();
        for (int i = 0; i < 5; i++) hit($urandom_range(exp_win_cyc() - 1, 0));
        hit(exp_win_cyc() - 1);
        end_wrong(1'b0);

        // Four hits shrink the window, then time out.
        start_game();
        for (int i = 0; i < 4; i++) hit($urandom_range(exp_win_cyc() - 1, 0));
        hit(exp_win_cyc() - 1);
        end_timeout();

        // Window floor holds after further speed-ups.
        start_game();
        for (int i = 0; i < 9; i++) hit($urandom_range(exp_win_cyc() - 1, 0));
        end_timeout();

        // Wrong button together with the target button.
        start_game();
        for (int i = 0; i < 2; i++) hit($urandom_range(exp_win_cyc() - 1, 0));
        end_wrong(1'b1);

        // Score saturation.
        start_game();
        for (int i = 0; i < 257; i++) hit($urandom_range(2, 0));
        end_wrong(1'b0);

        // Reset in the middle of a round, then a fresh game.
        start_game();
        hit($urandom_range(exp_win_cyc() - 1, 0));
        step();
        rst = 1'b1;
        step();
        chk("midrst_outs", {bus.toggle, bus.score, bus.busy, bus.game_over}, 0);
        rst = 1'b0;
        step();
        start_game();
        hit($urandom_range(exp_win_cyc() - 1, 0));
        end_timeout();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/led_game_ctrl.md
# led_game_ctrl

Game sequencer for the LED board. Drives an array of `toggle_led` instances through single-cycle toggle pulses and reads their `value` outputs back. It lights a pseudo-random LED and waits for the matching button. A hit scores and the game continues; a wrong button or a timeout ends the game. It sits between the debounced button inputs and the `toggle_led` array.

## Interface
- `N_LEDS`, 4: number of LEDs/buttons; power of two, 2..16.
- `TICK_DIV`, 50_000_000: clk cycles per game tick; ≥2.
- `TIMEOUT_TICKS`, 8: initial reaction window in ticks; 2..255.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; nonzero.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; starts or restarts a game from IDLE/OVER, ignored otherwise.
- `btn`  in  N_LEDS  one-cycle button pulses, already debounced.
- `led_state`  in  N_LEDS  `value` outputs of the `toggle_led` instances.
- `toggle`  out  N_LEDS  one-cycle pulses to the `toggle_led` `toggle` inputs; at most one bit high per cycle.
- `score`  out  8  hits this game; saturates at 255.
- `busy`  out  1  high in every state except IDLE/OVER.
- `game_over`  out  1  high in OVER.

## Operation
- FSM states: IDLE, PICK, SHOW, WAIT, CLEAR, FAIL, OVER.
- IDLE/OVER, `start`=1: clear `score` and the hit counter, set `window`=TIMEOUT_TICKS, go to PICK.
- PICK: `target` = LFSR[log2(N_LEDS)-1:0]; go to SHOW.
- SHOW: if `led_state[target]`=0, pulse `toggle[target]`. Clear the tick counters and go to WAIT either way.
- WAIT: evaluated in this priority order.
  - (1) Any `btn` bit ≠ `target` → FAIL. This applies even if the target bit is also set.
  - (2) `btn[target]` → `score`+1 (saturating) → CLEAR.
  - (3) Tick count = `window` → FAIL.
- CLEAR: pulse `toggle[target]` if `led_state[target]`=1. After every 4th hit, `window` = max(`window`−1, 2). Go to PICK.
- FAIL: pulse `toggle[target]` if `led_state[target]`=1; go to OVER.
- OVER: hold `score`. `btn` is ignored.
- LFSR: 16-bit Galois, taps 0xB400, shifts every cycle in all states.
- Tick logic: a cycle counter runs 0..TICK_DIV−1 in WAIT only; each wrap increments the tick count (8-bit).
- Outside IDLE, OVER and WAIT, `btn` and `start` are ignored.
- The block never pulses a LED that is already in the wanted state.

## Timing
- Reset (synchronous): state IDLE, `toggle`=0, `score`=0, `busy`=0, `game_over`=0, LFSR=`LFSR_SEED`, `window`=TIMEOUT_TICKS.
- Reset mid-game: all outputs reach reset values on the next edge. LEDs are cleared by the `toggle_led` instances' own `rst`, not by this block.
- `start` at edge t → PICK at t+1 → SHOW at t+2; `toggle` pulse asserted during SHOW.
- `toggle_led` updates `value` one cycle after the pulse. The CLEAR→PICK→SHOW path gives two cycles, so a repeated target reads as unlit in SHOW.
- Hit to next lit LED: 4 cycles (WAIT→CLEAR→PICK→SHOW, pulse in SHOW).
- Timeout fires on the edge where tick count reaches `window`, i.e. `window`×TICK_DIV cycles after entering WAIT, ±1 cycle.
- A button and a timeout in the same cycle: the button wins.
- `toggle` is registered and glitch-free: at most one bit high, for exactly one cycle per event.

## Structure
- Shared package `led_game_pkg`:
  - state encoding constants;
  - LFSR tap constant 16'hB400;
  - score width 8; hits per speed-up 4; minimum window 2.
- Sub-module `lfsr16`: `clk`, `rst`, `seed` param, 16-bit `q`, shifts every cycle.
- The rest (FSM, tick divider, score/window registers) is one always-block set in `led_game_ctrl`.

## Test plan
Bench parameters: N_LEDS=4, TICK_DIV=4, TIMEOUT_TICKS=3. The bench models four `toggle_led` instances.
- Reset, then idle 20 cycles → all outputs 0, no `toggle` pulses.
- `start` → SHOW is reached at t+2 with exactly one `toggle` bit pulsed, index = LFSR low 2 bits. The bench's expected `target` follows the same LFSR model. Pulse `btn[target]` in WAIT → `score`=1, a toggle pulse on the same index extinguishes it, a new LED lights 4 cycles after the hit.
- Press a wrong button, with and without `btn[target]` in the same cycle → target LED extinguished, `game_over`=1, `busy`=0, `score` unchanged.
- No button → FAIL at 12±1 cycles after WAIT entry; after 4 hits the next window is 8±1 cycles; the window never drops below 8 cycles.
- Button pulse in the exact timeout cycle → counts as a hit.
- Assert `rst` during WAIT → next cycle: IDLE, `score`=0, `toggle`=0. `start` in OVER → `score` cleared, new round runs.
